// File: rtl/clock_setup_ctrl.sv
// rtl/clock_setup_ctrl.sv - button sequencer for alarm-clock time/alarm setting and snooze
module clock_setup_ctrl #(
  parameter int REPEAT_DELAY = 2,
  parameter int TIMEOUT      = 30,
  parameter int SNOOZE_MIN   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_snooze,
  input  logic       alarm_active,
  input  logic [1:0] cur_hour1,
  input  logic [3:0] cur_hour0,
  input  logic [3:0] cur_min1,
  input  logic [3:0] cur_min0,
  output logic [1:0] Hour_in1,
  output logic [3:0] Hour_in0,
  output logic [3:0] Minute_in1,
  output logic [3:0] Minute_in0,
  output logic       Load_time,
  output logic       Load_alarm,
  output logic       Stop_alarm,
  output logic [2:0] edit_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_T_HOUR = 3'd1,
    S_T_MIN  = 3'd2,
    S_A_HOUR = 3'd3,
    S_A_MIN  = 3'd4
  } state_t;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int HW = $clog2(REPEAT_DELAY + 1);

  state_t          r_state, w_state_nxt;
  logic            r_mode_prev, r_up_prev, r_snz_prev;
  logic [1:0]      r_e_h1, w_e_h1;
  logic [3:0]      r_e_h0, r_e_m1, r_e_m0, w_e_h0, w_e_m1, w_e_m0;
  logic [1:0]      r_s_h1, w_s_h1;
  logic [3:0]      r_s_h0, r_s_m1, r_s_m0, w_s_h0, w_s_m1, w_s_m0;
  logic            r_snz_pend, w_snz_pend;
  logic            r_reload, w_reload;
  logic [TW-1:0]   r_to_cnt, w_to_cnt;
  logic [HW-1:0]   r_hold_cnt;
  logic [1:0]      r_hour_in1, w_hour_in1;
  logic [3:0]      r_hour_in0, r_min_in1, r_min_in0, w_hour_in0, w_min_in1, w_min_in0;
  logic            r_load_time, r_load_alarm, r_stop_alarm;
  logic            w_load_time, w_load_alarm, w_stop_alarm;

  logic w_mode_edge, w_up_edge, w_snz_edge, w_repeat, w_up_evt;
  assign w_mode_edge = btn_mode & ~r_mode_prev;
  assign w_up_edge   = btn_up & ~r_up_prev;
  assign w_snz_edge  = btn_snooze & ~r_snz_prev;
  assign w_repeat    = btn_up & r_up_prev & (r_hold_cnt >= HW'(REPEAT_DELAY));
  assign w_up_evt    = w_up_edge | w_repeat;

  // BCD increment of the edit fields; hours wrap at 23, minutes at 59
  logic       w_h_wrap;
  logic [1:0] w_inc_h1;
  logic [3:0] w_inc_h0, w_inc_m1, w_inc_m0;
  assign w_h_wrap = (r_e_h1 == 2'd2) && (r_e_h0 == 4'd3);
  assign w_inc_h1 = w_h_wrap ? 2'd0 : ((r_e_h0 == 4'd9) ? 2'(r_e_h1 + 2'd1) : r_e_h1);
  assign w_inc_h0 = (w_h_wrap || r_e_h0 == 4'd9) ? 4'd0 : 4'(r_e_h0 + 4'd1);
  assign w_inc_m0 = (r_e_m0 == 4'd9) ? 4'd0 : 4'(r_e_m0 + 4'd1);
  assign w_inc_m1 = (r_e_m0 != 4'd9) ? r_e_m1 : ((r_e_m1 == 4'd5) ? 4'd0 : 4'(r_e_m1 + 4'd1));

  logic [6:0] w_snz_mtot, w_snz_m;
  logic [4:0] w_snz_htot, w_snz_h;
  logic       w_snz_carry;
  assign w_snz_mtot  = 7'(cur_min1) * 7'd10 + 7'(cur_min0) + 7'(SNOOZE_MIN);
  assign w_snz_carry = (w_snz_mtot >= 7'd60);
  assign w_snz_m     = w_snz_carry ? 7'(w_snz_mtot - 7'd60) : w_snz_mtot;
  assign w_snz_htot  = 5'(cur_hour1) * 5'd10 + 5'(cur_hour0) + 5'(w_snz_carry);
  assign w_snz_h     = (w_snz_htot >= 5'd24) ? 5'(w_snz_htot - 5'd24) : w_snz_htot;

  always_comb begin
    w_state_nxt  = r_state;
    w_e_h1 = r_e_h1; w_e_h0 = r_e_h0; w_e_m1 = r_e_m1; w_e_m0 = r_e_m0;
    w_s_h1 = r_s_h1; w_s_h0 = r_s_h0; w_s_m1 = r_s_m1; w_s_m0 = r_s_m0;
    w_snz_pend   = r_snz_pend;
    w_reload     = 1'b0;
    w_to_cnt     = '0;
    w_hour_in1 = r_hour_in1; w_hour_in0 = r_hour_in0;
    w_min_in1  = r_min_in1;  w_min_in0  = r_min_in0;
    w_load_time  = 1'b0;
    w_load_alarm = 1'b0;
    w_stop_alarm = 1'b0;

    // Deferred restore of the real alarm after a snoozed alarm is dismissed
    if (r_reload) begin
      w_load_alarm = 1'b1;
      w_hour_in1 = r_s_h1; w_hour_in0 = r_s_h0; w_min_in1 = r_s_m1; w_min_in0 = r_s_m0;
      w_snz_pend = 1'b0;
    end

    if (r_state == S_IDLE) begin
      if (w_mode_edge) begin
        w_state_nxt = S_T_HOUR;
        w_e_h1 = cur_hour1; w_e_h0 = cur_hour0; w_e_m1 = cur_min1; w_e_m0 = cur_min0;
      end else if (alarm_active && w_snz_edge) begin
        w_stop_alarm = 1'b1;
        w_load_alarm = 1'b1;
        w_hour_in1 = 2'(w_snz_h / 5'd10);
        w_hour_in0 = 4'(w_snz_h % 5'd10);
        w_min_in1  = 4'(w_snz_m / 7'd10);
        w_min_in0  = 4'(w_snz_m % 7'd10);
        w_snz_pend = 1'b1;
      end else if (alarm_active && w_up_edge) begin
        w_stop_alarm = 1'b1;
        w_reload     = r_snz_pend;
      end
    end else begin
      if (w_mode_edge) begin
        case (r_state)
          S_T_HOUR: w_state_nxt = S_T_MIN;
          S_T_MIN: begin
            w_state_nxt = S_A_HOUR;
            w_load_time = 1'b1;
            w_hour_in1 = r_e_h1; w_hour_in0 = r_e_h0; w_min_in1 = r_e_m1; w_min_in0 = r_e_m0;
            w_e_h1 = r_s_h1; w_e_h0 = r_s_h0; w_e_m1 = r_s_m1; w_e_m0 = r_s_m0;
          end
          S_A_HOUR: w_state_nxt = S_A_MIN;
          default: begin
            w_state_nxt  = S_IDLE;
            w_load_alarm = 1'b1;
            w_hour_in1 = r_e_h1; w_hour_in0 = r_e_h0; w_min_in1 = r_e_m1; w_min_in0 = r_e_m0;
            w_s_h1 = r_e_h1; w_s_h0 = r_e_h0; w_s_m1 = r_e_m1; w_s_m0 = r_e_m0;
          end
        endcase
      end else if (w_up_evt) begin
        if (r_state == S_T_HOUR || r_state == S_A_HOUR) begin
          w_e_h1 = w_inc_h1; w_e_h0 = w_inc_h0;
        end else begin
          w_e_m1 = w_inc_m1; w_e_m0 = w_inc_m0;
        end
      end else if (r_to_cnt == TW'(TIMEOUT - 1)) begin
        w_state_nxt = S_IDLE;
      end else begin
        w_to_cnt = TW'(r_to_cnt + TW'(1));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_mode_prev <= 1'b0; r_up_prev <= 1'b0; r_snz_prev <= 1'b0;
      r_e_h1 <= '0; r_e_h0 <= '0; r_e_m1 <= '0; r_e_m0 <= '0;
      r_s_h1 <= '0; r_s_h0 <= '0; r_s_m1 <= '0; r_s_m0 <= '0;
      r_snz_pend <= 1'b0; r_reload <= 1'b0;
      r_to_cnt <= '0; r_hold_cnt <= '0;
      r_hour_in1 <= '0; r_hour_in0 <= '0; r_min_in1 <= '0; r_min_in0 <= '0;
      r_load_time <= 1'b0; r_load_alarm <= 1'b0; r_stop_alarm <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mode_prev <= btn_mode; r_up_prev <= btn_up; r_snz_prev <= btn_snooze;
      r_e_h1 <= w_e_h1; r_e_h0 <= w_e_h0; r_e_m1 <= w_e_m1; r_e_m0 <= w_e_m0;
      r_s_h1 <= w_s_h1; r_s_h0 <= w_s_h0; r_s_m1 <= w_s_m1; r_s_m0 <= w_s_m0;
      r_snz_pend <= w_snz_pend; r_reload <= w_reload;
      r_to_cnt <= w_to_cnt;
      if (!btn_up)
        r_hold_cnt <= '0;
      else if (w_up_edge)
        r_hold_cnt <= HW'(1);
      else if (r_hold_cnt < HW'(REPEAT_DELAY))
        r_hold_cnt <= HW'(r_hold_cnt + HW'(1));
      r_hour_in1 <= w_hour_in1; r_hour_in0 <= w_hour_in0;
      r_min_in1 <= w_min_in1; r_min_in0 <= w_min_in0;
      r_load_time <= w_load_time; r_load_alarm <= w_load_alarm; r_stop_alarm <= w_stop_alarm;
    end
  end

  assign Hour_in1   = r_hour_in1;
  assign Hour_in0   = r_hour_in0;
  assign Minute_in1 = r_min_in1;
  assign Minute_in0 = r_min_in0;
  assign Load_time  = r_load_time;
  assign Load_alarm = r_load_alarm;
  assign Stop_alarm = r_stop_alarm;
  assign edit_state = r_state;

endmodule
